// File: rtl/sec_pow_pkg.sv
// Shared definitions for the signed power unit: FSM state encodings and
// saturation / range-check helpers used by the multiplier.
package sec_pow_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic signed [63:0] sat_max(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

    // A product fits in out_w bits when every bit from out_w-1 upward is a copy of the sign.
    function automatic logic fits_out(input logic signed [63:0] p, input int out_w);
        logic signed [63:0] hi;
        hi = p >>> (out_w - 1);
        return (hi == 64'sd0) || (hi == -64'sd1);
    endfunction

endpackage

// File: rtl/pow_sat_mul.sv
// Combinational signed OUT_W x W multiply, saturated back to OUT_W bits,
// with a flag raised whenever the true product was clipped.
module pow_sat_mul
    import sec_pow_pkg::*;
#(
    parameter int W     = 4,
    parameter int OUT_W = 12
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [W-1:0]     a,
    output logic [OUT_W-1:0] prod,
    output logic             ovf
);

    logic signed [OUT_W+W-1:0] acc_x;
    logic signed [OUT_W+W-1:0] a_x;
    logic signed [OUT_W+W-1:0] p;
    logic signed [63:0]        p_ext;
    logic                      fit;

    always_comb begin
        acc_x = (OUT_W+W)'($signed(acc));
        a_x   = (OUT_W+W)'($signed(a));
        p     = acc_x * a_x;
        p_ext = 64'(p);
        fit   = fits_out(p_ext, OUT_W);
        if (fit) begin
            prod = p[OUT_W-1:0];
            ovf  = 1'b0;
        end else begin
            prod = p[OUT_W+W-1] ? OUT_W'(sat_min(OUT_W)) : OUT_W'(sat_max(OUT_W));
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/sec_pow_unit.sv
// Multi-cycle signed power unit: result = a^exp by repeated saturating
// multiplication through one shared multiplier, with a sticky overflow flag.
module sec_pow_unit
    import sec_pow_pkg::*;
#(
    parameter int W     = 4,
    parameter int EXP_W = 3,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);

    logic [1:0]       state_q,   state_d;
    logic [W-1:0]     a_q,       a_d;
    logic [EXP_W-1:0] cnt_q,     cnt_d;
    logic [OUT_W-1:0] acc_q,     acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [OUT_W-1:0] result_q,  result_d;
    logic             ovf_q,     ovf_d;

    logic [OUT_W-1:0] mul_prod;
    logic             mul_ovf;

    pow_sat_mul #(
        .W     (W),
        .OUT_W (OUT_W)
    ) u_mul (
        .acc  (acc_q),
        .a    (a_q),
        .prod (mul_prod),
        .ovf  (mul_ovf)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    cnt_d     = exp;
                    acc_d     = OUT_W'(1);
                    ovf_acc_d = 1'b0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    result_d = acc_q;
                    ovf_d    = ovf_acc_q;
                    state_d  = ST_DONE;
                end else begin
                    acc_d     = mul_prod;
                    ovf_acc_d = ovf_acc_q | mul_ovf;
                    cnt_d     = cnt_q - EXP_W'(1);
                    // Last multiply: publish straight from the multiplier so results land on the DONE edge.
                    if (cnt_q == EXP_W'(1)) begin
                        result_d = mul_prod;
                        ovf_d    = ovf_acc_q | mul_ovf;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_sec_pow_unit.sv
// Directed bench for sec_pow_unit: expected power/overflow/latency are queued
// at issue time and compared when the done pulse appears.
module tb_sec_pow_unit;

    localparam int W     = 4;
    localparam int EXP_W = 3;
    localparam int OUT_W = 12;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [W-1:0]     a      = '0;
    logic [EXP_W-1:0] exp_in = '0;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result;
    logic             ovf;

    typedef struct {
        int res;
        bit ovf;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   last_res  = 0;
    bit   last_ovf  = 1'b0;

    always #5 clk = ~clk;

    sec_pow_unit #(
        .W     (W),
        .EXP_W (EXP_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .exp    (exp_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    task automatic expectEq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // True power with the accumulator clipped to the signed result range after every step.
    function automatic exp_t modelPow(input int av, input int ev);
        exp_t r;
        int   acc;
        int   p;
        int   maxv;
        int   minv;
        maxv  = (1 << (OUT_W - 1)) - 1;
        minv  = -(1 << (OUT_W - 1));
        acc   = 1;
        r.ovf = 1'b0;
        for (int i = 0; i < ev; i++) begin
            p = acc * av;
            if (p > maxv) begin
                acc   = maxv;
                r.ovf = 1'b1;
            end else if (p < minv) begin
                acc   = minv;
                r.ovf = 1'b1;
            end else begin
                acc = p;
            end
        end
        r.res = acc;
        r.lat = (ev == 0) ? 1 : ev;
        return r;
    endfunction

    task automatic applyStimulus(input int av, input int ev);
        sb.push_back(modelPow(av, ev));
        start  = 1'b1;
        a      = W'(av);
        exp_in = EXP_W'(ev);
        @(negedge clk);
        start = 1'b0;
        expectEq("accept_busy", busy, 1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            expectEq({tag, "_hold_res"}, $signed(result), last_res);
            expectEq({tag, "_hold_ovf"}, ovf, last_ovf);
            @(negedge clk);
            n++;
        end
        expectEq({tag, "_done"}, done, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            expectEq({tag, "_lat"}, n, e.lat);
            expectEq({tag, "_res"}, $signed(result), e.res);
            expectEq({tag, "_ovf"}, ovf, e.ovf);
            last_res = e.res;
            last_ovf = e.ovf;
        end
        @(negedge clk);
        expectEq({tag, "_pulse"}, done, 0);
        expectEq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int prev;
        int pulses;
        int k;

        #12;
        expectEq("rst_busy", busy, 0);
        expectEq("rst_done", done, 0);
        expectEq("rst_res", $signed(result), 0);
        expectEq("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(-3, 3);
        checkOutput("cube_m3");
        expectEq("cube_m3_const", $signed(result), -27);

        for (int i = -8; i < 8; i++) begin
            applyStimulus(i, 3);
            checkOutput("sweep");
        end
        expectEq("sweep_last_const", $signed(result), 343);

        applyStimulus(-8, 3);
        checkOutput("cube_m8");
        expectEq("cube_m8_const", $signed(result), -512);

        applyStimulus(-8, 0);
        checkOutput("exp0");
        expectEq("exp0_const", $signed(result), 1);
        applyStimulus(0, 5);
        checkOutput("zero_base");
        applyStimulus(-1, 6);
        checkOutput("m1_even");
        applyStimulus(-1, 7);
        checkOutput("m1_odd");
        expectEq("m1_odd_const", $signed(result), -1);

        applyStimulus(-8, 7);
        checkOutput("sat_alt");
        expectEq("sat_alt_const", $signed(result), -2048);
        expectEq("sat_alt_ovf_const", ovf, 1);
        applyStimulus(7, 4);
        checkOutput("sat_pos");
        expectEq("sat_pos_const", $signed(result), 2047);
        applyStimulus(2, 3);
        checkOutput("ovf_clear");

        // Start held high: each busy period must accept exactly once.
        start  = 1'b1;
        a      = 4'd2;
        exp_in = 3'd2;
        prev   = -1;
        pulses = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (prev >= 0) expectEq("cadence", cyc - prev, 4);
                expectEq("hold_start_res", $signed(result), 4);
                prev = cyc;
                pulses++;
            end else if (prev >= 0) begin
                expectEq("hold_start_stable", $signed(result), 4);
            end
        end
        start = 1'b0;
        expectEq("hold_start_pulses", pulses, 6);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        expectEq("hold_start_idle", busy, 0);
        last_res = 4;
        last_ovf = 1'b0;

        start  = 1'b1;
        a      = 4'd2;
        exp_in = 3'd7;
        @(negedge clk);
        start = 1'b0;
        expectEq("midrst_busy_pre", busy, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expectEq("midrst_busy", busy, 0);
        expectEq("midrst_done", done, 0);
        expectEq("midrst_res", $signed(result), 0);
        expectEq("midrst_ovf", ovf, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            expectEq("midrst_no_done", done, 0);
        end
        rst_n    = 1'b1;
        last_res = 0;
        last_ovf = 1'b0;
        @(negedge clk);
        applyStimulus(3, 2);
        checkOutput("after_rst");
        expectEq("after_rst_const", $signed(result), 9);

        applyStimulus(5, 2);
        a      = 4'b1000;
        exp_in = 3'd7;
        checkOutput("latched");
        expectEq("latched_const", $signed(result), 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
